// File: rtl/target_box_locator.sv
// target_box_locator
//   Scans the binary (eroded) pixel stream of one frame in raster order and grows up to
//   three foreground bounding boxes. A foreground pixel joins the lowest-index box it is
//   within MERGE_DIST of; otherwise it opens the lowest free box, or is dropped and flagged
//   as overflow when all boxes are in use. On frame_end the boxes that meet the minimum
//   size are published and held for the whole next frame, and the working boxes restart
//   empty.
//
// Ports
//   video_clk     in   pixel clock, all logic on its rising edge
//   rst           in   synchronous active-high reset
//   pix_valid     in   active_x/active_y/pix_data valid this cycle
//   pix_data      in   binary pixel, 1 = foreground
//   active_x      in   12-bit column of the current pixel
//   active_y      in   12-bit row of the current pixel (non-decreasing within a frame)
//   frame_end     in   one-cycle pulse after the last pixel of a frame
//   loc_out1..3   out  48-bit box {top,bottom,left,right}, zero when not qualified
//   loc_valid     out  bit i set when loc_out(i+1) holds a qualified box
//   box_overflow  out  last frame dropped a foreground pixel for lack of a free box
//   frame_done    out  one-cycle pulse, outputs updated this cycle

module target_box_locator #(
  parameter int unsigned MERGE_DIST = 16,
  parameter int unsigned MIN_W      = 8,
  parameter int unsigned MIN_H      = 8
) (
  input  logic        video_clk,
  input  logic        rst,
  input  logic        pix_valid,
  input  logic        pix_data,
  input  logic [11:0] active_x,
  input  logic [11:0] active_y,
  input  logic        frame_end,
  output logic [47:0] loc_out1,
  output logic [47:0] loc_out2,
  output logic [47:0] loc_out3,
  output logic [2:0]  loc_valid,
  output logic        box_overflow,
  output logic        frame_done
);

  localparam int unsigned NumSlots = 3;
  localparam logic [12:0] MergeDist = 13'(MERGE_DIST);
  localparam logic [12:0] MinW      = 13'(MIN_W);
  localparam logic [12:0] MinH      = 13'(MIN_H);

  // Working slots
  logic [NumSlots-1:0] used_q, used_d;
  logic [11:0]         top_q   [NumSlots];
  logic [11:0]         top_d   [NumSlots];
  logic [11:0]         bot_q   [NumSlots];
  logic [11:0]         bot_d   [NumSlots];
  logic [11:0]         left_q  [NumSlots];
  logic [11:0]         left_d  [NumSlots];
  logic [11:0]         right_q [NumSlots];
  logic [11:0]         right_d [NumSlots];
  logic                ovf_q, ovf_d;

  // Published results
  logic [47:0]         loc_q   [NumSlots];
  logic [47:0]         box_d   [NumSlots];
  logic [NumSlots-1:0] valid_q, qual;
  logic                ovf_out_q;
  logic                frame_done_q;

  logic [NumSlots-1:0] match;
  logic                hit, free;
  logic [1:0]          hit_idx, free_idx;
  logic [12:0]         x13, y13;
  logic                pix_fg;

  // Widen to 13 bits so the +MERGE_DIST windows never wrap past 4095.
  assign x13    = {1'b0, active_x};
  assign y13    = {1'b0, active_y};
  assign pix_fg = pix_valid && pix_data && !frame_end;

  always_comb begin : match_logic
    hit      = 1'b0;
    hit_idx  = '0;
    free     = 1'b0;
    free_idx = '0;
    for (int i = 0; i < NumSlots; i++) begin
      match[i] = used_q[i]
                 && (x13 + MergeDist >= {1'b0, left_q[i]})
                 && (x13 <= {1'b0, right_q[i]} + MergeDist)
                 && (y13 <= {1'b0, bot_q[i]} + MergeDist);
    end
    // Descending scan leaves the lowest index selected.
    for (int i = NumSlots - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit     = 1'b1;
        hit_idx = 2'(i);
      end
      if (!used_q[i]) begin
        free     = 1'b1;
        free_idx = 2'(i);
      end
    end
  end

  always_comb begin : slot_next
    used_d  = used_q;
    top_d   = top_q;
    bot_d   = bot_q;
    left_d  = left_q;
    right_d = right_q;
    ovf_d   = ovf_q;
    if (frame_end) begin
      // frame_end wins over a coincident pixel.
      used_d = '0;
      ovf_d  = 1'b0;
      for (int i = 0; i < NumSlots; i++) begin
        top_d[i]   = '0;
        bot_d[i]   = '0;
        left_d[i]  = '0;
        right_d[i] = '0;
      end
    end else if (pix_fg) begin
      if (hit) begin
        for (int i = 0; i < NumSlots; i++) begin
          if (hit_idx == 2'(i)) begin
            if (active_x < left_q[i])  left_d[i]  = active_x;
            if (active_x > right_q[i]) right_d[i] = active_x;
            if (active_y > bot_q[i])   bot_d[i]   = active_y;
          end
        end
      end else if (free) begin
        for (int i = 0; i < NumSlots; i++) begin
          if (free_idx == 2'(i)) begin
            used_d[i]  = 1'b1;
            top_d[i]   = active_y;
            bot_d[i]   = active_y;
            left_d[i]  = active_x;
            right_d[i] = active_x;
          end
        end
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_comb begin : qualify
    for (int i = 0; i < NumSlots; i++) begin
      qual[i] = used_q[i]
                && ({1'b0, right_q[i]} - {1'b0, left_q[i]} + 13'd1 >= MinW)
                && ({1'b0, bot_q[i]} - {1'b0, top_q[i]} + 13'd1 >= MinH);
      box_d[i] = qual[i] ? {top_q[i], bot_q[i], left_q[i], right_q[i]} : 48'd0;
    end
  end

  always_ff @(posedge video_clk) begin
    if (rst) begin
      used_q       <= '0;
      ovf_q        <= 1'b0;
      valid_q      <= '0;
      ovf_out_q    <= 1'b0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < NumSlots; i++) begin
        top_q[i]   <= '0;
        bot_q[i]   <= '0;
        left_q[i]  <= '0;
        right_q[i] <= '0;
        loc_q[i]   <= '0;
      end
    end else begin
      used_q       <= used_d;
      ovf_q        <= ovf_d;
      frame_done_q <= frame_end;
      for (int i = 0; i < NumSlots; i++) begin
        top_q[i]   <= top_d[i];
        bot_q[i]   <= bot_d[i];
        left_q[i]  <= left_d[i];
        right_q[i] <= right_d[i];
      end
      if (frame_end) begin
        valid_q   <= qual;
        ovf_out_q <= ovf_q;
        for (int i = 0; i < NumSlots; i++) begin
          loc_q[i] <= box_d[i];
        end
      end
    end
  end

  assign loc_out1     = loc_q[0];
  assign loc_out2     = loc_q[1];
  assign loc_out3     = loc_q[2];
  assign loc_valid    = valid_q;
  assign box_overflow = ovf_out_q;
  assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_target_box_locator.sv
// Bench for target_box_locator: directed frames plus random blob frames, each checked
// against a box-tracking model kept here in plain integer arithmetic.

module tb_target_box_locator;

  localparam int MD = 16;
  localparam int MW = 8;
  localparam int MH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pix_valid = 1'b0;
  logic        pix_data = 1'b0;
  logic [11:0] active_x = '0;
  logic [11:0] active_y = '0;
  logic        frame_end = 1'b0;
  logic [47:0] loc_out1, loc_out2, loc_out3;
  logic [2:0]  loc_valid;
  logic        box_overflow, frame_done;

  target_box_locator #(.MERGE_DIST(MD), .MIN_W(MW), .MIN_H(MH)) dut (
    .video_clk   (clk),
    .rst         (rst),
    .pix_valid   (pix_valid),
    .pix_data    (pix_data),
    .active_x    (active_x),
    .active_y    (active_y),
    .frame_end   (frame_end),
    .loc_out1    (loc_out1),
    .loc_out2    (loc_out2),
    .loc_out3    (loc_out3),
    .loc_valid   (loc_valid),
    .box_overflow(box_overflow),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model state
  int          m_used[3], m_top[3], m_bot[3], m_left[3], m_right[3];
  bit          m_ovf;
  logic [47:0] e_loc[3];
  logic [2:0]  e_valid;
  logic        e_ovf;

  // Rectangles making up the current frame
  int rx0[8], ry0[8], rw[8], rh[8];
  int nrect;

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      m_used[i] = 0; m_top[i] = 0; m_bot[i] = 0; m_left[i] = 0; m_right[i] = 0;
    end
    m_ovf = 0;
  endtask

  task automatic model_pix(input int x, input int y);
    bit done = 0;
    for (int i = 0; i < 3 && !done; i++) begin
      if (m_used[i] != 0 && x + MD >= m_left[i] && x <= m_right[i] + MD && y <= m_bot[i] + MD)
      begin
        if (x < m_left[i])  m_left[i]  = x;
        if (x > m_right[i]) m_right[i] = x;
        if (y > m_bot[i])   m_bot[i]   = y;
        done = 1;
      end
    end
    for (int i = 0; i < 3 && !done; i++) begin
      if (m_used[i] == 0) begin
        m_used[i] = 1; m_top[i] = y; m_bot[i] = y; m_left[i] = x; m_right[i] = x;
        done = 1;
      end
    end
    if (!done) m_ovf = 1;
  endtask

  task automatic model_frame_end();
    for (int i = 0; i < 3; i++) begin
      if (m_used[i] != 0 && m_right[i] - m_left[i] + 1 >= MW && m_bot[i] - m_top[i] + 1 >= MH)
      begin
        e_loc[i]   = {12'(m_top[i]), 12'(m_bot[i]), 12'(m_left[i]), 12'(m_right[i])};
        e_valid[i] = 1'b1;
      end else begin
        e_loc[i]   = '0;
        e_valid[i] = 1'b0;
      end
    end
    e_ovf = m_ovf;
    model_clear();
  endtask

  task automatic check_out(input logic fd);
    check("frame_done", 48'(frame_done), 48'(fd));
    check("loc_out1", loc_out1, e_loc[0]);
    check("loc_out2", loc_out2, e_loc[1]);
    check("loc_out3", loc_out3, e_loc[2]);
    check("loc_valid", 48'(loc_valid), 48'(e_valid));
    check("box_overflow", 48'(box_overflow), 48'(e_ovf));
  endtask

  task automatic drive(input int x, input int y, input logic d, input logic v);
    @(negedge clk);
    pix_valid = v; pix_data = d; active_x = 12'(x); active_y = 12'(y); frame_end = 1'b0;
    if (v && d) model_pix(x, y);
  endtask

  // Drive frame_end for one cycle, optionally with a foreground pixel that must be dropped.
  task automatic fe_drive(input bit with_pix, input int x, input int y);
    frame_end = 1'b1; pix_valid = with_pix; pix_data = 1'b1;
    active_x = 12'(x); active_y = 12'(y);
    model_frame_end();
  endtask

  task automatic end_frame();
    @(negedge clk); fe_drive(0, 0, 0);
    @(negedge clk); frame_end = 1'b0; pix_valid = 1'b0;
    check_out(1'b1);
    @(negedge clk); check_out(1'b0);
  endtask

  task automatic add_rect(input int x, input int y, input int w, input int h);
    rx0[nrect] = x; ry0[nrect] = y; rw[nrect] = w; rh[nrect] = h;
    nrect++;
  endtask

  // Raster scan of a window, sending foreground pixels and a sprinkling of background ones.
  task automatic scan(input int xlo, input int xhi, input int ylo, input int yhi);
    for (int y = ylo; y <= yhi; y++) begin
      for (int x = xlo; x <= xhi; x++) begin
        bit in = 0;
        for (int r = 0; r < nrect; r++)
          if (x >= rx0[r] && x < rx0[r] + rw[r] && y >= ry0[r] && y < ry0[r] + rh[r]) in = 1;
        if (in) begin
          if ($urandom_range(0, 31) == 0) drive(x, y, 1'b1, 1'b0);  // invalid cycle, ignored
          drive(x, y, 1'b1, 1'b1);
        end else if ($urandom_range(0, 63) == 0) begin
          drive(x, y, 1'b0, 1'($urandom_range(0, 1)));
        end
      end
    end
    nrect = 0;
  endtask

  initial begin
    nrect = 0;
    model_clear();
    for (int i = 0; i < 3; i++) e_loc[i] = '0;
    e_valid = '0; e_ovf = 1'b0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_out(1'b0);

    // 1: single 20x10 blob
    add_rect(100, 50, 20, 10);
    scan(90, 130, 45, 65);
    end_frame();
    check("t1_loc1", loc_out1, {12'd50, 12'd59, 12'd100, 12'd119});
    check("t1_valid", 48'(loc_valid), 48'd1);

    // 2: two blobs side by side
    add_rect(10, 5, 20, 20);
    add_rect(200, 5, 20, 20);
    scan(0, 230, 0, 30);
    end_frame();
    check("t2_loc1", loc_out1, {12'd5, 12'd24, 12'd10, 12'd29});
    check("t2_loc2", loc_out2, {12'd5, 12'd24, 12'd200, 12'd219});
    check("t2_valid", 48'(loc_valid), 48'd3);

    // 2b: 15-pixel gap joins slot 0
    add_rect(10, 0, 10, 10);
    add_rect(35, 0, 10, 10);
    scan(0, 60, 0, 12);
    end_frame();
    check("t2_gap15", loc_out1, {12'd0, 12'd9, 12'd10, 12'd44});
    check("t2_gap15_v", 48'(loc_valid), 48'd1);

    // 2c: 17-pixel gap opens slot 1
    add_rect(10, 0, 10, 10);
    add_rect(37, 0, 10, 10);
    scan(0, 60, 0, 12);
    end_frame();
    check("t2_gap17", loc_out2, {12'd0, 12'd9, 12'd37, 12'd46});
    check("t2_gap17_v", 48'(loc_valid), 48'd3);

    // 3: four blobs, fourth overflows; next clean frame clears the flag
    for (int k = 0; k < 4; k++) add_rect(40 * k, 0, 10, 10);
    scan(0, 140, 0, 12);
    end_frame();
    check("t3_valid", 48'(loc_valid), 48'd7);
    check("t3_ovf", 48'(box_overflow), 48'd1);
    add_rect(20, 20, 10, 10);
    scan(0, 40, 15, 35);
    end_frame();
    check("t3_ovf_clr", 48'(box_overflow), 48'd0);

    // 4: single-pixel noise plus a 5-wide blob, neither qualifies
    add_rect(300, 0, 1, 1);
    add_rect(10, 2, 5, 20);
    scan(0, 300, 0, 22);
    end_frame();
    check("t4_valid", 48'(loc_valid), 48'd0);
    check("t4_loc1", loc_out1, 48'd0);

    // 5: pixel with frame_end, then a second frame_end straight after
    add_rect(50, 50, 10, 10);
    scan(45, 65, 45, 65);
    @(negedge clk); fe_drive(1, 100, 0);
    @(negedge clk); check_out(1'b1); fe_drive(0, 0, 0);
    @(negedge clk); frame_end = 1'b0; pix_valid = 1'b0;
    check_out(1'b1);
    check("t5_zero", {loc_out1 | loc_out2 | loc_out3}, 48'd0);
    @(negedge clk); check_out(1'b0);
    // Leaked pixel at (100,0) would have become the top-left of this box.
    @(negedge clk); fe_drive(1, 100, 0);
    @(negedge clk); frame_end = 1'b0; pix_valid = 1'b0; check_out(1'b1);
    add_rect(104, 3, 10, 10);
    scan(95, 120, 0, 15);
    end_frame();
    check("t5_noleak", loc_out1, {12'd3, 12'd12, 12'd104, 12'd113});

    // 6: reset mid-frame
    add_rect(10, 10, 10, 10);
    add_rect(100, 10, 10, 10);
    scan(0, 120, 0, 15);
    @(negedge clk); rst = 1'b1; pix_valid = 1'b0;
    model_clear();
    for (int i = 0; i < 3; i++) e_loc[i] = '0;
    e_valid = '0; e_ovf = 1'b0;
    @(negedge clk); rst = 1'b0;
    check_out(1'b0);
    repeat (3) @(negedge clk);
    check_out(1'b0);
    add_rect(60, 30, 12, 9);
    scan(50, 80, 25, 45);
    end_frame();
    check("t6_loc1", loc_out1, {12'd30, 12'd38, 12'd60, 12'd71});
    check("t6_valid", 48'(loc_valid), 48'd1);

    // Edge of the coordinate range: windows must not wrap at 4095
    add_rect(4080, 4086, 16, 10);
    scan(4060, 4095, 4080, 4095);
    end_frame();
    check("edge_loc1", loc_out1, {12'd4086, 12'd4095, 12'd4080, 12'd4095});

    // Random frames
    for (int f = 0; f < 8; f++) begin
      int n = $urandom_range(1, 5);
      for (int k = 0; k < n; k++)
        add_rect($urandom_range(0, 100), $urandom_range(0, 40),
                 $urandom_range(1, 20), $urandom_range(1, 20));
      scan(0, 127, 0, 63);
      end_frame();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
